// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Width-independent descriptions of the fixed results.
    // Divide by zero: quotient is all ones (remainder is the dividend).
    localparam logic DIV0_QUOT_BIT = 1'b1;
    // Signed overflow: quotient is the most negative value, remainder is zero.
    localparam logic OVF_QUOT_MSB  = 1'b1;
    localparam logic OVF_REM_BIT   = 1'b0;

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage side of the multiply/divide unit: operands in, stall/result out.
interface muldiv_if #(parameter int WIDTH = 32);

    logic             Valid_i;
    logic [2:0]       Funct3_i;
    logic [WIDTH-1:0] SrcA_i;
    logic [WIDTH-1:0] SrcB_i;
    logic [4:0]       Rd_i;
    logic             Kill_i;
    logic             StallReq_o;
    logic             Done_o;
    logic [WIDTH-1:0] Result_o;
    logic [4:0]       RdOut_o;

    // Pipeline / hazard-logic side.
    modport master (
        output Valid_i, Funct3_i, SrcA_i, SrcB_i, Rd_i, Kill_i,
        input  StallReq_o, Done_o, Result_o, RdOut_o
    );

    // Multiply/divide unit side.
    modport slave (
        input  Valid_i, Funct3_i, SrcA_i, SrcB_i, Rd_i, Kill_i,
        output StallReq_o, Done_o, Result_o, RdOut_o
    );

endinterface

// File: rtl/muldiv_div_restore_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial
// subtract, keep the difference when it does not borrow.
// Assumes rem < divisor on entry, so the new remainder fits in WIDTH bits.
module div_restore_step #(parameter int WIDTH = 32) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dividend_bit,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Trial subtraction; the top bit of the difference is the borrow.
    always_comb begin
        shifted  = {rem, dividend_bit};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[WIDTH];
        rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Raises a stall request while computing and presents a registered result
// for one DONE cycle. Execute-stage kill abandons the operation.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for an M op; start is combinational on Valid_i
// CALC    | one multiply/divide bit per cycle, WIDTH cycles total
// DONE    | Result_o/RdOut_o valid, Done_o high, pipeline advances
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state, state_next;
    logic [CNT_W-1:0] cnt;
    funct3_e          op_f3;
    logic [4:0]       rd_q;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] op_reg;
    logic [WIDTH-1:0] acc_hi, acc_lo;
    logic [WIDTH-1:0] result_q;

    logic             start, stall, done, last_iter;
    funct3_e          f3_in;
    logic             a_signed, b_signed, in_sign_a, in_sign_b;
    logic [WIDTH-1:0] in_mag_a, in_mag_b;
    logic             div_zero, div_ovf, special;
    logic [WIDTH-1:0] ovf_quot, special_res;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   div_rem;
    logic               div_q;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, final_res;

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem          (acc_hi),
        .divisor      (op_reg),
        .dividend_bit (acc_lo[WIDTH-1]),
        .rem_next     (div_rem),
        .q_bit        (div_q)
    );

    // Operand decode at start: signedness, magnitudes and the two early-out cases.
    always_comb begin
        f3_in     = funct3_e'(bus.Funct3_i);
        a_signed  = (f3_in == F3_MULH) || (f3_in == F3_MULHSU) ||
                    (f3_in == F3_DIV)  || (f3_in == F3_REM);
        b_signed  = (f3_in == F3_MULH) || (f3_in == F3_DIV) || (f3_in == F3_REM);
        in_sign_a = a_signed & bus.SrcA_i[WIDTH-1];
        in_sign_b = b_signed & bus.SrcB_i[WIDTH-1];
        in_mag_a  = in_sign_a ? -bus.SrcA_i : bus.SrcA_i;
        in_mag_b  = in_sign_b ? -bus.SrcB_i : bus.SrcB_i;
        ovf_quot  = {OVF_QUOT_MSB, {(WIDTH-1){~OVF_QUOT_MSB}}};
        div_zero  = f3_in[2] && (bus.SrcB_i == '0);
        div_ovf   = ((f3_in == F3_DIV) || (f3_in == F3_REM)) &&
                    (bus.SrcA_i == ovf_quot) && (bus.SrcB_i == '1);
        special   = div_zero | div_ovf;
        if (div_zero)
            special_res = f3_in[1] ? bus.SrcA_i : {WIDTH{DIV0_QUOT_BIT}};
        else
            special_res = f3_in[1] ? {WIDTH{OVF_REM_BIT}} : ovf_quot;
    end

    // One iteration of shift-add multiply or restoring divide, plus the sign fix
    // applied on the final iteration.
    always_comb begin
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_reg} : {(WIDTH+1){1'b0}});
        if (op_f3[2]) begin
            step_hi = div_rem;
            step_lo = {acc_lo[WIDTH-2:0], div_q};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
        prod      = {step_hi, step_lo};
        prod_fix  = (sign_a ^ sign_b) ? -prod : prod;
        quot_fix  = (sign_a ^ sign_b) ? -step_lo : step_lo;
        rem_fix   = sign_a ? -step_hi : step_hi;
        if (op_f3[2])
            final_res = op_f3[1] ? rem_fix : quot_fix;
        else if (op_f3 == F3_MUL)
            final_res = prod_fix[WIDTH-1:0];
        else
            final_res = prod_fix[2*WIDTH-1:WIDTH];
        last_iter = (cnt == CNT_LAST);
    end

    // Next-state and handshake outputs; kill overrides everything.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        done       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                start = bus.Valid_i & ~bus.Kill_i & ~rst;
                if (start)
                    state_next = special ? ST_DONE : ST_CALC;
            end
            ST_CALC: begin
                if (bus.Kill_i)
                    state_next = ST_IDLE;
                else if (last_iter)
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = ~bus.Kill_i;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        stall = start | ((state == ST_CALC) & ~bus.Kill_i);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Datapath: capture at start, iterate in CALC, latch the result on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            op_f3    <= F3_MUL;
            rd_q     <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            op_reg   <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            result_q <= '0;
        end else if (start) begin
            cnt    <= '0;
            op_f3  <= f3_in;
            rd_q   <= bus.Rd_i;
            sign_a <= in_sign_a;
            sign_b <= in_sign_b;
            acc_hi <= '0;
            op_reg <= f3_in[2] ? in_mag_b : in_mag_a;
            acc_lo <= f3_in[2] ? in_mag_a : in_mag_b;
            if (special)
                result_q <= special_res;
        end else if ((state == ST_CALC) && !bus.Kill_i) begin
            cnt    <= cnt + 1'b1;
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            if (last_iter)
                result_q <= final_res;
        end
    end

    assign bus.StallReq_o = stall;
    assign bus.Done_o     = done;
    assign bus.Result_o   = result_q;
    assign bus.RdOut_o    = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, kill/reset
// behaviour and randomized operations against a plain-arithmetic model.
module tb_muldiv_unit;

    localparam logic [31:0] MIN_S = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ua, ub, q;
        logic [63:0] p;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        r  = '0;
        case (f3)
            3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
            3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
            3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == MIN_S && b == 32'hFFFF_FFFF) r = MIN_S;
                else begin q = sa / sb; r = q[31:0]; end
            end
            3'd5: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else begin q = ua / ub; r = q[31:0]; end
            end
            3'd6: begin
                if (b == 0) r = a;
                else if (a == MIN_S && b == 32'hFFFF_FFFF) r = 32'h0;
                else begin q = sa % sb; r = q[31:0]; end
            end
            default: begin
                if (b == 0) r = a;
                else begin q = ua % ub; r = q[31:0]; end
            end
        endcase
        return r;
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        return (f3 >= 3'd4 && b == 0) ||
               ((f3 == 3'd4 || f3 == 3'd6) && a == MIN_S && b == 32'hFFFF_FFFF);
    endfunction

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
        logic [31:0] exp_res;
        int          exp_stall, stalls;
        bit          seen;
        exp_res   = ref_model(f3, a, b);
        exp_stall = is_special(f3, a, b) ? 1 : 33;
        @(negedge clk);
        bus.Valid_i  = 1'b1;
        bus.Funct3_i = f3;
        bus.SrcA_i   = a;
        bus.SrcB_i   = b;
        bus.Rd_i     = rd;
        bus.Kill_i   = 1'b0;
        stalls = 0;
        seen   = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            #1;
            if (bus.Done_o) begin
                seen = 1'b1;
                check("stall_len", 64'(stalls), 64'(exp_stall));
                check("done_stall", 64'(bus.StallReq_o), 64'd0);
                check("result", 64'(bus.Result_o), 64'(exp_res));
                check("rd_out", 64'(bus.RdOut_o), 64'(rd));
            end else if (bus.StallReq_o) begin
                stalls++;
            end
            @(negedge clk);
        end
        bus.Valid_i = 1'b0;
        if (!seen) begin
            check("done_timeout", 64'd0, 64'd1);
        end else begin
            #1;
            check("hold_result", 64'(bus.Result_o), 64'(exp_res));
            check("done_pulse", 64'(bus.Done_o), 64'd0);
        end
    endtask

    task automatic expect_no_done(input string tag, input int cycles);
        int dones;
        dones = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            #1;
            if (bus.Done_o) dones++;
        end
        check(tag, 64'(dones), 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return MIN_S;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.Valid_i  = 1'b0;
        bus.Funct3_i = 3'd0;
        bus.SrcA_i   = '0;
        bus.SrcB_i   = '0;
        bus.Rd_i     = '0;
        bus.Kill_i   = 1'b0;

        @(negedge clk);
        #1;
        check("rst_stall", 64'(bus.StallReq_o), 64'd0);
        check("rst_done", 64'(bus.Done_o), 64'd0);
        check("rst_result", 64'(bus.Result_o), 64'd0);
        check("rst_rd", 64'(bus.RdOut_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases from the RV32M corner list.
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd2);
        run_op(3'd1, 32'hFFFF_FFF9, 32'd3, 5'd3);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5);
        run_op(3'd5, 32'd100, 32'd7, 5'd6);
        run_op(3'd7, 32'd100, 32'd7, 5'd7);
        run_op(3'd4, 32'd5, 32'd0, 5'd8);
        run_op(3'd6, 32'd5, 32'd0, 5'd10);
        run_op(3'd4, MIN_S, 32'hFFFF_FFFF, 5'd11);
        run_op(3'd6, MIN_S, 32'hFFFF_FFFF, 5'd12);
        run_op(3'd5, MIN_S, 32'hFFFF_FFFF, 5'd13);

        // Kill in the middle of a DIV.
        @(negedge clk);
        bus.Valid_i  = 1'b1;
        bus.Funct3_i = 3'd4;
        bus.SrcA_i   = 32'hFFFF_FFF9;
        bus.SrcB_i   = 32'd2;
        bus.Rd_i     = 5'd20;
        for (int c = 0; c < 10; c++) @(negedge clk);
        bus.Kill_i = 1'b1;
        #1;
        check("kill_stall", 64'(bus.StallReq_o), 64'd0);
        check("kill_done", 64'(bus.Done_o), 64'd0);
        @(negedge clk);
        bus.Kill_i  = 1'b0;
        bus.Valid_i = 1'b0;
        #1;
        check("kill_idle_stall", 64'(bus.StallReq_o), 64'd0);
        expect_no_done("kill_no_done", 40);
        run_op(3'd0, 32'd3, 32'd4, 5'd21);

        // Kill in the same cycle as a would-be start.
        @(negedge clk);
        bus.Valid_i  = 1'b1;
        bus.Kill_i   = 1'b1;
        bus.Funct3_i = 3'd0;
        bus.SrcA_i   = 32'd6;
        bus.SrcB_i   = 32'd6;
        #1;
        check("kill_start_stall", 64'(bus.StallReq_o), 64'd0);
        @(negedge clk);
        bus.Valid_i = 1'b0;
        bus.Kill_i  = 1'b0;
        #1;
        check("kill_start_idle", 64'(bus.StallReq_o), 64'd0);
        expect_no_done("kill_start_no_done", 40);

        // Asynchronous reset in the middle of a MUL.
        @(negedge clk);
        bus.Valid_i  = 1'b1;
        bus.Funct3_i = 3'd0;
        bus.SrcA_i   = 32'd9;
        bus.SrcB_i   = 32'd9;
        bus.Rd_i     = 5'd17;
        for (int c = 0; c < 5; c++) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_stall", 64'(bus.StallReq_o), 64'd0);
        check("arst_done", 64'(bus.Done_o), 64'd0);
        check("arst_result", 64'(bus.Result_o), 64'd0);
        check("arst_rd", 64'(bus.RdOut_o), 64'd0);
        @(negedge clk);
        bus.Valid_i = 1'b0;
        rst = 1'b0;
        expect_no_done("arst_no_done", 40);
        run_op(3'd0, 32'd3, 32'd4, 5'd22);

        // Randomized operations.
        for (int i = 0; i < 150; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            logic [4:0]  rd;
            f3 = 3'($urandom_range(0, 7));
            a  = pick_operand();
            b  = pick_operand();
            rd = 5'($urandom_range(0, 31));
            run_op(f3, a, b, rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage of the pipelined core. It is the producer side of the stall protocol: while an M-extension instruction is being computed, it raises a stall request, and the hazard logic turns that into F/D/PC enable deassertion. It honours the execute-stage kill from the control-hazard path. When the request drops, the result is presented for the E→M pipeline register.

## Interface
- `WIDTH`, default 32: operand/result width; iteration count equals `WIDTH`.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `Valid_i`, in, 1: the E-stage instruction is an M-extension op.
- `Funct3_i`, in, 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `SrcA_i`, in, `WIDTH`: rs1 value, after forwarding.
- `SrcB_i`, in, `WIDTH`: rs2 value, after forwarding.
- `Rd_i`, in, 5: destination register of the E-stage instruction.
- `Kill_i`, in, 1: E-stage flush; abandons the operation in progress.
- `StallReq_o`, out, 1: hold PC/F/D/E this cycle.
- `Done_o`, out, 1: `Result_o` is valid this cycle.
- `Result_o`, out, `WIDTH`: computed result.
- `RdOut_o`, out, 5: destination register captured at start.

## Operation
- States: IDLE, CALC, DONE.
- Start condition: `start = Valid_i & ~Kill_i & (state==IDLE)`.
- IDLE→CALC on `start`.
  - Capture operand magnitudes and sign flags per funct3: MULH signs both operands, MULHSU signs A only, DIV/REM sign both.
  - Capture funct3 and Rd. Clear the counter.
- IDLE→DONE directly on `start` in either special case:
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give `SrcA_i`.
  - Signed overflow (A = 0x8000_0000, B = 0xFFFF_FFFF): DIV gives 0x8000_0000; REM gives 0.
- CALC, multiply: shift-add, one bit of B per cycle, into a 2·`WIDTH` accumulator.
- CALC, divide: restoring algorithm, one quotient bit per cycle.
- CALC→DONE when the counter reaches `WIDTH`-1.
- Final sign fix in the CALC→DONE transition:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Result select: MUL returns the low half; MULH/MULHSU/MULHU return the high half.
- DONE→IDLE unconditionally. `Valid_i` is ignored in DONE, because the pipeline advances during DONE.
- `StallReq_o = start | (state==CALC)`. This is a combinational term, because the instruction must be held in E from its first cycle.
- `Kill_i` in any state:
  - Next state is IDLE.
  - `StallReq_o` is 0 in that cycle.
  - `Done_o` is never asserted for the killed op.
- Reset values: state IDLE; `StallReq_o`=0, `Done_o`=0, `Result_o`=0, `RdOut_o`=0; counter and accumulators 0.

## Timing
- Start at cycle T: `StallReq_o`=1 in cycles T..T+`WIDTH` (33 cycles at 32). DONE occurs at T+`WIDTH`+1, with `Done_o`=1 and `StallReq_o`=0.
- Special case: `StallReq_o`=1 in cycle T only; DONE occurs at T+1.
- `Result_o` and `RdOut_o` are registered and held stable until the next start.
- Back-to-back M ops: the next op can start at the earliest in the cycle after DONE.
- Reset asserted during CALC: state is IDLE immediately (asynchronous), and no Done is produced.
- `Kill_i` and `start` in the same cycle: kill wins and nothing starts.

## Structure
- `muldiv_pkg`:
  - funct3 enum.
  - State enum.
  - Constants for the div-by-zero and overflow values.
- Sub-module `div_restore_step` (combinational): one restoring iteration.
  - Input: partial remainder, divisor, next dividend bit.
  - Output: new remainder and quotient bit.
  - The multiply step stays inline.

## Test plan
- MUL 7×(−3), SrcA=7, SrcB=0xFFFF_FFFD: `StallReq_o` high for 33 cycles; then `Done_o` with `Result_o`=0xFFFF_FFEB and `RdOut_o`=`Rd_i`.
- MULHU 0xFFFF_FFFF×0xFFFF_FFFF gives 0xFFFF_FFFE. MULHSU 0xFFFF_FFFF×2 gives 0xFFFF_FFFF.
- Division signs:
  - DIV −7/2 gives 0xFFFF_FFFD; REM −7/2 gives 0xFFFF_FFFF.
  - DIVU 100/7 gives 14; REMU 100/7 gives 2.
- Divide by zero, DIV 5/0: 0xFFFF_FFFF with a 1-cycle stall. Overflow, DIV 0x8000_0000/−1: 0x8000_0000 with a 1-cycle stall.
- `Kill_i` at cycle T+10 of a DIV:
  - `StallReq_o` drops that cycle.
  - State returns to IDLE.
  - No `Done_o`.
  - A new MUL 3×4 started afterwards gives 12.
- `rst` asserted at T+5 of a MUL: all outputs are 0 immediately, and no `Done_o` follows.
